// File: rtl/mem_lsu_if.sv
// Core-side request/response and RAM-side port bundle of the load/store unit.
// slave is the LSU view; master is the core plus RAM view.
interface mem_lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic        mem_w_en;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  req_valid, req_store, req_funct3, req_addr, req_wdata, resp_ready, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_w_en, mem_wdata
  );

  modport master (
    output req_valid, req_store, req_funct3, req_addr, req_wdata, resp_ready, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_w_en, mem_wdata
  );
endinterface

// File: rtl/mem_lsu.sv
// Single-outstanding load/store unit in front of a 4-byte-port data RAM.
// Sub-word stores go through read-modify-write; bad accesses never reach the RAM.
module mem_lsu #(
  parameter int unsigned RAM_BYTES = 4096
) (
  input  logic      i_clk,
  input  logic      i_rst,
  mem_lsu_if.slave  bus
);

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RMW_RD,
    S_WRITE,
    S_RESP
  } state_t;

  state_t          r_state;
  logic [2:0]      r_f3;
  logic [AW-1:0]   r_addr;
  logic [15:0]     r_wdata;
  logic            r_req_ready;
  logic            r_resp_valid;
  logic [DW-1:0]   r_rdata;
  logic            r_err;
  logic            r_w_en;
  logic [DW-1:0]   r_mem_wdata;

  logic            w_f3_ok;
  logic            w_misalign;
  logic            w_range;
  logic            w_err;
  logic [DW-1:0]   w_load_ext;
  logic [DW-1:0]   w_merge;

  // Request legality, judged on the raw request inputs at accept time.
  always_comb begin
    w_f3_ok = 1'b0;
    if (bus.req_store) w_f3_ok = bus.req_funct3 inside {3'b000, 3'b001, 3'b010};
    else               w_f3_ok = bus.req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    w_misalign = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
                 ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));
    // 33-bit compare so addresses near 2^32 cannot wrap into range
    w_range = {1'b0, bus.req_addr} > 33'(RAM_BYTES - 4);
    w_err   = !w_f3_ok || w_misalign || w_range;
  end

  // Load extension and sub-word store merge from the RAM read word.
  always_comb begin
    w_load_ext = bus.mem_rdata;
    case (r_f3)
      3'b000:  w_load_ext = {{24{bus.mem_rdata[7]}}, bus.mem_rdata[7:0]};
      3'b100:  w_load_ext = {24'd0, bus.mem_rdata[7:0]};
      3'b001:  w_load_ext = {{16{bus.mem_rdata[15]}}, bus.mem_rdata[15:0]};
      3'b101:  w_load_ext = {16'd0, bus.mem_rdata[15:0]};
      default: w_load_ext = bus.mem_rdata;
    endcase
    if (r_f3[0]) w_merge = {bus.mem_rdata[31:16], r_wdata};
    else         w_merge = {bus.mem_rdata[31:8], r_wdata[7:0]};
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_f3         <= 3'd0;
      r_addr       <= '0;
      r_wdata      <= 16'd0;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_rdata      <= '0;
      r_err        <= 1'b0;
      r_w_en       <= 1'b0;
      r_mem_wdata  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.req_valid) begin
            r_f3        <= bus.req_funct3;
            r_addr      <= bus.req_addr;
            r_wdata     <= bus.req_wdata[15:0];
            r_req_ready <= 1'b0;
            if (w_err) begin
              r_state      <= S_RESP;
              r_resp_valid <= 1'b1;
              r_err        <= 1'b1;
              r_rdata      <= '0;
            end else if (!bus.req_store) begin
              r_state <= S_LOAD;
            end else if (bus.req_funct3 == 3'b010) begin
              r_state     <= S_WRITE;
              r_w_en      <= 1'b1;
              r_mem_wdata <= bus.req_wdata;
            end else begin
              r_state <= S_RMW_RD;
            end
          end
        end
        S_LOAD: begin
          r_state      <= S_RESP;
          r_rdata      <= w_load_ext;
          r_err        <= 1'b0;
          r_resp_valid <= 1'b1;
        end
        S_RMW_RD: begin
          r_state     <= S_WRITE;
          r_mem_wdata <= w_merge;
          r_w_en      <= 1'b1;
        end
        S_WRITE: begin
          r_state      <= S_RESP;
          r_w_en       <= 1'b0;
          r_rdata      <= '0;
          r_err        <= 1'b0;
          r_resp_valid <= 1'b1;
        end
        S_RESP: begin
          if (bus.resp_ready) begin
            r_state      <= S_IDLE;
            r_resp_valid <= 1'b0;
            r_req_ready  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready  = r_req_ready;
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_rdata = r_rdata;
  assign bus.resp_err   = r_err;
  assign bus.mem_addr   = r_addr;
  // Reset overrides the write strobe so the reset edge never writes the RAM
  assign bus.mem_w_en   = r_w_en & ~i_rst;
  assign bus.mem_wdata  = r_mem_wdata;

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu with a byte-array RAM model behind the unit.
module tb_mem_lsu;

  localparam int unsigned RAM_BYTES = 4096;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   passed = 0;
  int   total  = 0;

  logic [7:0]  ram [0:RAM_BYTES+2];
  logic        pl_en = 1'b0;
  int          pl_addr = 0;
  logic [31:0] pl_data = '0;

  mem_lsu_if bus();

  mem_lsu #(.RAM_BYTES(RAM_BYTES)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // RAM model: combinational 4-byte read, write at posedge; pl_* preloads words
  always_comb begin
    int ix;
    ix = int'(bus.mem_addr[11:0]);
    bus.mem_rdata = {ram[ix+3], ram[ix+2], ram[ix+1], ram[ix]};
  end

  always @(posedge clk) begin
    if (bus.mem_w_en) begin
      for (int k = 0; k < 4; k++) ram[int'(bus.mem_addr[11:0]) + k] <= bus.mem_wdata[8*k +: 8];
    end
    if (pl_en) begin
      for (int k = 0; k < 4; k++) ram[pl_addr + k] <= pl_data[8*k +: 8];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic poke(input int a, input logic [31:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    tick();
    pl_en = 1'b0;
  endtask

  // One request through to handshake; latencies counted in cycles after the accept edge
  task automatic txn(input string tag, input logic st, input logic [2:0] f3,
                     input logic [31:0] addr, input logic [31:0] wd,
                     input int exp_lat, input logic [31:0] exp_rd, input logic exp_err,
                     input int exp_wen_cyc, input logic [31:0] exp_wd, input int hold);
    int          lat, wen_cnt, wen_cyc;
    logic [31:0] wd_seen;
    lat = 0; wen_cnt = 0; wen_cyc = 0; wd_seen = '0;
    chk({tag, "_req_ready"}, 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1; bus.req_store = st; bus.req_funct3 = f3;
    bus.req_addr = addr; bus.req_wdata = wd;
    tick();
    bus.req_valid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      if (bus.mem_w_en) begin wen_cnt++; wen_cyc = k; wd_seen = bus.mem_wdata; end
      if (bus.resp_valid) begin lat = k; break; end
      tick();
    end
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_rdata"}, bus.resp_rdata, exp_rd);
    chk({tag, "_err"}, 32'(bus.resp_err), 32'(exp_err));
    chk({tag, "_wen_cnt"}, 32'(wen_cnt), (exp_wen_cyc != 0) ? 32'd1 : 32'd0);
    chk({tag, "_wen_cyc"}, 32'(wen_cyc), 32'(exp_wen_cyc));
    if (exp_wen_cyc != 0) chk({tag, "_wdata"}, wd_seen, exp_wd);
    // Stall the response; a stray request meanwhile must be ignored
    for (int h = 0; h < hold; h++) begin
      bus.req_valid = 1'b1; bus.req_store = 1'b1; bus.req_funct3 = 3'b010;
      bus.req_addr = 32'h30; bus.req_wdata = 32'hBAD0BAD0;
      tick();
      chk({tag, "_hold"}, {bus.resp_valid, bus.req_ready, bus.mem_w_en, bus.resp_err, bus.resp_rdata[27:0]},
          {1'b1, 1'b0, 1'b0, exp_err, exp_rd[27:0]});
    end
    bus.req_valid = 1'b0;
    bus.resp_ready = 1'b1;
    tick();
    bus.resp_ready = 1'b0;
    chk({tag, "_after_hs"}, {30'd0, bus.resp_valid, bus.req_ready}, 32'b01);
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_store = 1'b0; bus.req_funct3 = 3'b000;
    bus.req_addr = '0; bus.req_wdata = '0; bus.resp_ready = 1'b0;
    tick(); tick();
    chk("rst_outputs", {26'd0, bus.req_ready, bus.resp_valid, bus.resp_err, bus.mem_w_en, 2'b00}, 32'b100000);
    chk("rst_rdata", bus.resp_rdata, 32'd0);
    chk("rst_addr", bus.mem_addr, 32'd0);
    chk("rst_wdata", bus.mem_wdata, 32'd0);
    rst = 1'b0;
    poke(32'h10, 32'h3412FF80);
    poke(32'h14, 32'h00000000);
    poke(32'h30, 32'h00000000);
    poke(4092, 32'h11223344);

    txn("lw10",  1'b0, 3'b010, 32'h10, 32'h0, 2, 32'h3412FF80, 1'b0, 0, 32'h0, 0);
    txn("lb10",  1'b0, 3'b000, 32'h10, 32'h0, 2, 32'hFFFFFF80, 1'b0, 0, 32'h0, 0);
    txn("lbu10", 1'b0, 3'b100, 32'h10, 32'h0, 2, 32'h00000080, 1'b0, 0, 32'h0, 0);
    txn("lh10",  1'b0, 3'b001, 32'h10, 32'h0, 2, 32'hFFFFFF80, 1'b0, 0, 32'h0, 0);
    txn("lhu12", 1'b0, 3'b101, 32'h12, 32'h0, 2, 32'h00003412, 1'b0, 0, 32'h0, 0);
    txn("lwtop", 1'b0, 3'b010, 32'd4092, 32'h0, 2, 32'h11223344, 1'b0, 0, 32'h0, 0);

    // Sub-word store: bytes 0x10..0x14 = 00 11 22 33 44
    poke(32'h10, 32'h33221100);
    poke(32'h14, 32'h00000044);
    txn("sb11",  1'b1, 3'b000, 32'h11, 32'hAAAAAA5A, 3, 32'h0, 1'b0, 2, 32'h4433225A, 0);
    txn("lw10b", 1'b0, 3'b010, 32'h10, 32'h0, 2, 32'h33225A00, 1'b0, 0, 32'h0, 0);
    txn("lw14",  1'b0, 3'b010, 32'h14, 32'h0, 2, 32'h00000044, 1'b0, 0, 32'h0, 0);
    txn("sh12",  1'b1, 3'b001, 32'h12, 32'h1234BEEF, 3, 32'h0, 1'b0, 2, 32'h0044BEEF, 0);
    txn("lw10c", 1'b0, 3'b010, 32'h10, 32'h0, 2, 32'hBEEF5A00, 1'b0, 0, 32'h0, 0);

    txn("sw20",  1'b1, 3'b010, 32'h20, 32'hDEADBEEF, 2, 32'h0, 1'b0, 1, 32'hDEADBEEF, 0);
    txn("lw20",  1'b0, 3'b010, 32'h20, 32'h0, 2, 32'hDEADBEEF, 1'b0, 0, 32'h0, 0);

    txn("e_lh3",   1'b0, 3'b001, 32'h3, 32'h0, 1, 32'h0, 1'b1, 0, 32'h0, 0);
    txn("e_sw6",   1'b1, 3'b010, 32'h6, 32'h0, 1, 32'h0, 1'b1, 0, 32'h0, 0);
    txn("e_f3_011",1'b0, 3'b011, 32'h0, 32'h0, 1, 32'h0, 1'b1, 0, 32'h0, 0);
    txn("e_sb100", 1'b1, 3'b100, 32'h0, 32'h0, 1, 32'h0, 1'b1, 0, 32'h0, 0);
    txn("e_lwtop", 1'b0, 3'b010, 32'(RAM_BYTES - 2), 32'h0, 1, 32'h0, 1'b1, 0, 32'h0, 0);
    txn("e_lbtop", 1'b0, 3'b000, 32'(RAM_BYTES - 3), 32'h0, 1, 32'h0, 1'b1, 0, 32'h0, 0);
    txn("e_lwwrap",1'b0, 3'b010, 32'hFFFFFFFC, 32'h0, 1, 32'h0, 1'b1, 0, 32'h0, 0);

    // Stalled response, then back-to-back accept; 0x30 must stay untouched
    txn("stall",  1'b0, 3'b010, 32'h20, 32'h0, 2, 32'hDEADBEEF, 1'b0, 0, 32'h0, 5);
    txn("b2b30",  1'b0, 3'b010, 32'h30, 32'h0, 2, 32'h00000000, 1'b0, 0, 32'h0, 0);

    // Reset during the WRITE cycle of an sb
    poke(32'h40, 32'h44332211);
    poke(32'h44, 32'h00000055);
    bus.req_valid = 1'b1; bus.req_store = 1'b1; bus.req_funct3 = 3'b000;
    bus.req_addr = 32'h40; bus.req_wdata = 32'h000000FF;
    tick();
    bus.req_valid = 1'b0;
    tick();
    chk("rstw_in_write", 32'(bus.mem_w_en), 32'd1);
    rst = 1'b1;
    #1;
    chk("rstw_wen_gated", 32'(bus.mem_w_en), 32'd0);
    tick();
    rst = 1'b0;
    chk("rstw_outputs", {26'd0, bus.req_ready, bus.resp_valid, bus.resp_err, bus.mem_w_en, 2'b00}, 32'b100000);
    chk("rstw_rdata", bus.resp_rdata, 32'd0);
    chk("rstw_addr", bus.mem_addr, 32'd0);
    chk("rstw_wdata", bus.mem_wdata, 32'd0);
    txn("lw40",  1'b0, 3'b010, 32'h40, 32'h0, 2, 32'h44332211, 1'b0, 0, 32'h0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
